nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle wide adder that drives one instance of the team's `four_bit_adder` as its datapath. It presents one 4-bit slice of the operands per clock, least-significant nibble first, and registers the carry between slices. It collects the sum slices into a WIDTH-bit result register. Used wherever a wide add is needed and area matters more than latency; upstream logic hands it operands with a start pulse and consumes the result on `done`.

## Interface
- `WIDTH`, default 16: operand and result width in bits.
  - Must be a multiple of 4 and ≥ 4.
  - N = WIDTH/4 is the number of nibble steps.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request a new addition. Sampled on the rising edge of `clk`; only accepted when `busy` = 0.
- `A` input, WIDTH bits: operand A, captured on start acceptance.
- `B` input, WIDTH bits: operand B, captured on start acceptance.
- `Cin` input, 1 bit: carry-in to nibble 0, captured on start acceptance.
- `Sum` output, WIDTH bits: registered result.
- `Cout` output, 1 bit: registered carry-out of the most significant nibble.
- `busy` output, 1 bit: high while nibble steps are in progress.
- `done` output, 1 bit: one-cycle pulse; `Sum`/`Cout` are final while it is high.

## Operation
- States:
  - IDLE
  - RUN
  - DONE
- Internal registers:
  - operand registers `a_r`, `b_r` (WIDTH bits each)
  - carry register `c_r`
  - nibble index `idx`, width clog2(N) (min 1 bit)
- Datapath: the `four_bit_adder` instance gets `A = a_r[4*idx +: 4]`, `B = b_r[4*idx +: 4]`, `Cin = c_r`. Its outputs are purely combinational into the RUN-state update.
- IDLE or DONE, with `start` = 1 at an edge:
  - `a_r` ← `A`, `b_r` ← `B`, `c_r` ← `Cin`, `idx` ← 0.
  - `Sum` ← 0, `Cout` ← 0.
  - Go to RUN.
- IDLE, with `start` = 0: hold all state.
- DONE, with `start` = 0: go to IDLE.
- RUN, each edge:
  - `Sum[4*idx +: 4]` ← adder Sum.
  - `c_r` ← adder Cout.
  - If `idx` = N-1: `Cout` ← adder Cout, go to DONE.
  - Otherwise: `idx` ← `idx` + 1.
- `start` in RUN is ignored; it does not queue and does not alter the operands.
- Arithmetic: {`Cout`, `Sum`} = `A` + `B` + `Cin`, modulo 2^(WIDTH+1), with no truncation. `Sum` wraps modulo 2^WIDTH.
- Outputs hold their last value in IDLE until the next accepted start clears them.
- `busy` = (state == RUN); `done` = (state == DONE). Both are decoded from registered state, with no combinational path from inputs.
- Reset: asynchronous and effective immediately, including mid-operation. The block returns to IDLE with:
  - `Sum` = 0, `Cout` = 0, `busy` = 0, `done` = 0
  - `a_r` = 0, `b_r` = 0, `c_r` = 0, `idx` = 0
  - Any in-flight operation is discarded without a `done` pulse.
  - The first start is accepted on the first rising edge after `rst` deasserts.

## Timing
- Start accepted at edge t → `busy` high from t until edge t+N.
- Nibble k is written at edge t+1+k, for k = 0..N-1.
- `done` is high for exactly one cycle, between edges t+N and t+N+1. Latency from start to done is N cycles (4 for WIDTH = 16).
- Back-to-back: a `start` sampled at edge t+N+1, while `done` is high, is accepted. The new RUN begins without an IDLE cycle, so throughput is one result per N+1 cycles.
- WIDTH = 4: a single RUN cycle, and `done` follows start by 1 cycle.
- `Sum` bits above nibble k read 0 during RUN (cleared at start). A consumer must sample `Sum` only when `done` = 1 or later.

## Test plan
- Reset: assert `rst` mid-cycle with no clock edge.
  - Required: `Sum` = 0, `Cout` = 0, `busy` = 0, `done` = 0 immediately.
  - Then deassert `rst`, pulse `start` with A = 16'h0001, B = 16'h0001 → `Sum` = 16'h0002.
- Basic add, WIDTH = 16: A = 16'h1234, B = 16'h4321, Cin = 0.
  - Required: `busy` for 4 cycles, then `done` pulse of 1 cycle with `Sum` = 16'h5555, `Cout` = 0.
  - `Sum` stays 16'h5555 afterwards in IDLE.
- Full carry ripple: A = 16'hFFFF, B = 16'h0001, Cin = 0 → `Sum` = 16'h0000, `Cout` = 1.
  - Also A = 16'hFFFF, B = 16'hFFFF, Cin = 1 → `Sum` = 16'hFFFF, `Cout` = 1.
- Start during busy: start A = 16'h00F0, B = 16'h0010.
  - At the 2nd RUN cycle, assert `start` with A = 16'hAAAA, B = 16'h5555.
  - Required: `done` at the original time with `Sum` = 16'h0100, `Cout` = 0; no second `done` follows.
- Back-to-back: assert `start` during the `done` cycle with A = 16'h8000, B = 16'h8000, Cin = 1.
  - Required: `busy` on the next cycle, then `done` 4 cycles later with `Sum` = 16'h0001, `Cout` = 1.
- Reset mid-operation: assert `rst` after 2 RUN cycles of A = 16'h1111, B = 16'h2222.
  - Required: no `done` pulse; all outputs 0.
  - A following start with A = 16'h0003, B = 16'h0004, Cin = 1 → `Sum` = 16'h0008, `Cout` = 0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one four_bit_adder is reused across WIDTH/4 clocks,
// least-significant nibble first, with the carry held in a register between slices.

module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             c_r;
    logic [IW-1:0]    idx;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             accept;

    four_bit_adder u_add (
        .A    (a_r[4*idx +: 4]),
        .B    (b_r[4*idx +: 4]),
        .Cin  (c_r),
        .Sum  (nib_sum),
        .Cout (nib_cout)
    );

    // A start is honoured from IDLE and also from DONE, so results can stream back to back.
    assign accept = start && (state != RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            c_r  <= 1'b0;
            idx  <= '0;
            Sum  <= '0;
            Cout <= 1'b0;
        end else if (accept) begin
            a_r  <= A;
            b_r  <= B;
            c_r  <= Cin;
            idx  <= '0;
            Sum  <= '0;
            Cout <= 1'b0;
        end else if (state == RUN) begin
            Sum[4*idx +: 4] <= nib_sum;
            c_r             <= nib_cout;
            if (idx == LAST) Cout <= nib_cout;
            else             idx  <= idx + 1'b1;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH = 16.

module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout, busy, done;

    int checks = 0;
    int passed = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .Sum   (sum),
        .Cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a = av; b = bv; cin = cv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the accepting edge; returns sampling the done cycle.
    task automatic wait_done(input string tag, input logic [16:0] exp);
        for (int i = 0; i < N; i++) begin
            check({tag, "_busy"}, {31'b0, busy}, 32'd1);
            check({tag, "_nodone"}, {31'b0, done}, 32'd0);
            tick();
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
        check({tag, "_result"}, {15'b0, cout, sum}, {15'b0, exp});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        check("por_outputs", {14'b0, busy, done, cout, sum}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        issue(16'h1234, 16'h4321, 1'b0);
        wait_done("basic", 17'h05555);
        tick();
        check("basic_done_pulse", {31'b0, done}, 32'd0);
        tick(); tick();
        check("basic_hold", {15'b0, cout, sum}, 32'h5555);

        // Asynchronous reset mid-cycle, no clock edge involved.
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst", {14'b0, busy, done, cout, sum}, 32'd0);
        #3;
        rst = 1'b0;
        issue(16'h0001, 16'h0001, 1'b0);
        wait_done("after_rst", 17'h00002);
        tick();

        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ripple1", 17'h10000);
        tick();
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("ripple2", 17'h1FFFF);
        tick();

        // Start while busy is ignored.
        issue(16'h00F0, 16'h0010, 1'b0);
        tick();
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ign_done", {31'b0, done}, 32'd1);
        check("ign_result", {15'b0, cout, sum}, 32'h0100);

        // Back to back: start during the done cycle.
        a = 16'h8000; b = 16'h8000; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_no_idle", {30'b0, busy, done}, 32'd2);
        wait_done("b2b", 17'h10001);
        tick();
        for (int i = 0; i < 6; i++) check("no_extra_done", {30'b0, busy, done}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("ign_quiet", {30'b0, busy, done}, 32'd0);

        // Reset in the middle of an operation.
        issue(16'h1111, 16'h2222, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midop_rst", {14'b0, busy, done, cout, sum}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            check("midop_nodone", {30'b0, busy, done}, 32'd0);
            tick();
        end
        issue(16'h0003, 16'h0004, 1'b1);
        wait_done("post_midop", 17'h00008);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
